// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial capture register: clr seeds a new word with din, en shifts din in.
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] shifted;

    // The first bit of a word sits where new bits enter: LSB when shifting left, MSB when shifting right.
    always_comb begin
        if (MSB_FIRST) begin
            seed    = {{(WIDTH-1){1'b0}}, din};
            shifted = {q[WIDTH-2:0], din};
        end else begin
            seed    = {din, {(WIDTH-1){1'b0}}};
            shifted = {din, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= seed;
        end else if (en) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Reassembles WIDTH-bit words from a framed serial stream into a valid/ready holding register.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_start,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int unsigned CW = cnt_w(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] word;
    logic             clr;
    logic             en;
    logic             complete;
    logic             load;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .din   (s_data),
        .q     (q)
    );

    // The completed word is formed combinationally so it reaches p_data on the same edge as the last bit.
    always_comb begin
        clr      = s_valid & s_start;
        en       = s_valid & ~s_start & (state == SHIFT);
        complete = en & (cnt == CW'(WIDTH - 1));
        load     = complete & (~p_valid | p_ready);
        if (MSB_FIRST) begin
            word = {q[WIDTH-2:0], s_data};
        end else begin
            word = {s_data, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            p_data    <= '0;
            p_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= clr & (state == SHIFT);
            overrun   <= complete & p_valid & ~p_ready;

            if (clr) begin
                state <= SHIFT;
                cnt   <= CW'(1);
            end else if (complete) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (en) begin
                cnt <= cnt + CW'(1);
            end

            if (load) begin
                p_data  <= word;
                p_valid <= 1'b1;
            end else if (p_valid & p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed and random checks of both bit orders against a word-level reference model.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_data = 1'b0;
    logic       s_start = 1'b0;
    logic       p_ready = 1'b0;
    logic [7:0] pd_m, pd_l;
    logic       pv_m, pv_l, ovr_m, ovr_l, fe_m, fe_l;

    int n_assert = 0;
    int n_fail   = 0;
    int ovr_seen = 0;

    // Reference model state
    int         nbits = 0;
    logic       bits [8];
    logic       e_pv = 1'b0;
    logic [7:0] e_pd_m = '0;
    logic [7:0] e_pd_l = '0;
    logic       e_ovr = 1'b0;
    logic       e_fe = 1'b0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
        .p_data(pd_m), .p_valid(pv_m), .p_ready(p_ready), .overrun(ovr_m), .frame_err(fe_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
        .p_data(pd_l), .p_valid(pv_l), .p_ready(p_ready), .overrun(ovr_l), .frame_err(fe_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic v, input logic d, input logic st, input logic rdy, input logic rn);
        logic       done;
        logic [7:0] wm, wl;
        if (!rn) begin
            nbits = 0; e_pv = 0; e_pd_m = '0; e_pd_l = '0; e_ovr = 0; e_fe = 0;
            return;
        end
        done = 0; e_fe = 0; e_ovr = 0;
        if (v) begin
            if (st) begin
                e_fe = (nbits > 0);
                bits[0] = d;
                nbits = 1;
            end else if (nbits > 0) begin
                bits[nbits] = d;
                nbits++;
                if (nbits == 8) begin
                    done = 1;
                    nbits = 0;
                end
            end
        end
        if (done) begin
            wm = '0; wl = '0;
            for (int i = 0; i < 8; i++) begin
                wm[7-i] = bits[i];
                wl[i]   = bits[i];
            end
            if (!e_pv || rdy) begin
                e_pv = 1; e_pd_m = wm; e_pd_l = wl;
            end else begin
                e_ovr = 1;
            end
        end else if (e_pv && rdy) begin
            e_pv = 0;
        end
    endtask

    task automatic tick(input logic v, input logic d, input logic st, input logic rdy, input logic rn);
        s_valid = v; s_data = d; s_start = st; p_ready = rdy; rst_n = rn;
        model(v, d, st, rdy, rn);
        @(posedge clk);
        #1;
        if (ovr_m) ovr_seen++;
        chk("p_valid_m", {31'b0, pv_m}, {31'b0, e_pv});
        chk("p_valid_l", {31'b0, pv_l}, {31'b0, e_pv});
        chk("p_data_m", {24'b0, pd_m}, {24'b0, e_pd_m});
        chk("p_data_l", {24'b0, pd_l}, {24'b0, e_pd_l});
        chk("overrun_m", {31'b0, ovr_m}, {31'b0, e_ovr});
        chk("overrun_l", {31'b0, ovr_l}, {31'b0, e_ovr});
        chk("frame_err_m", {31'b0, fe_m}, {31'b0, e_fe});
        chk("frame_err_l", {31'b0, fe_l}, {31'b0, e_fe});
    endtask

    // Sends w first-bit-first from w[7]; p_ready is rdy for all but the last bit, which uses rdy_last.
    task automatic send_word(input logic [7:0] w, input int gap, input logic rdy, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            tick(1'b1, w[i], (i == 7), (i == 0) ? rdy_last : rdy, 1'b1);
            if (i > 0) begin
                for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, rdy, 1'b1);
            end
        end
    endtask

    initial begin
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_p_data", {24'b0, pd_m}, 32'h0);
        chk("reset_p_valid", {31'b0, pv_m}, 32'h0);

        // A5, ready high: valid for exactly one cycle
        send_word(8'hA5, 0, 1'b1, 1'b1);
        chk("a5_msb", {24'b0, pd_m}, 32'hA5);
        chk("a5_lsb", {24'b0, pd_l}, 32'hA5);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("a5_valid_drop", {31'b0, pv_m}, 32'h0);

        send_word(8'hC0, 0, 1'b1, 1'b1);
        chk("c0_msb", {24'b0, pd_m}, 32'hC0);
        chk("c0_lsb", {24'b0, pd_l}, 32'h03);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Gaps of three idle cycles between bits
        send_word(8'h3C, 3, 1'b1, 1'b1);
        chk("3c_gap", {24'b0, pd_m}, 32'h3C);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Overrun: second word dropped while the first is held
        ovr_seen = 0;
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b0);
        chk("ovr_hold", {24'b0, pd_m}, 32'h11);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_once", ovr_seen, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_drain", {31'b0, pv_m}, 32'h0);

        // Consume in the same cycle the next word completes
        send_word(8'h11, 0, 1'b0, 1'b0);
        ovr_seen = 0;
        send_word(8'h22, 0, 1'b0, 1'b1);
        chk("simul_data", {24'b0, pd_m}, 32'h22);
        chk("simul_valid", {31'b0, pv_m}, 32'h1);
        chk("simul_no_ovr", ovr_seen, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Resync after 5 bits, then a full 5A word
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, i[0], 1'b0, 1'b1, 1'b1);
        send_word(8'h5A, 0, 1'b1, 1'b1);
        chk("resync_data", {24'b0, pd_m}, 32'h5A);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-frame, then bits without s_start are ignored
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_data", {24'b0, pd_m}, 32'h0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_ignore", {31'b0, pv_m}, 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                 1'($urandom), ($urandom_range(0, 99) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
